sq_window_acc: RTL

Windowed sum-of-squares accumulator that sits directly downstream of the combinational squarer. It consumes one squared sample per accepted transfer and sums exactly 2^LOG_N samples per window. It then presents the window sum and the floor mean through a valid/ready output register. Typical consumers are power/energy estimators in the AGC and detection paths.

---
 rtl/sq_acc_pkg.sv | 22 ++
 rtl/sq_acc_out_reg.sv | 40 ++++
 rtl/sq_window_acc.sv | 107 ++++++++++
 3 files changed

// File: rtl/sq_acc_pkg.sv
// Shared types and width helpers for the windowed sum-of-squares accumulator.
package sq_acc_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned LOG_N_DEF = 4;

  typedef enum logic {
    ACC   = 1'b0,
    STALL = 1'b1
  } acc_state_e;

  // SQ_W: width of one squared sample.
  function automatic int unsigned sq_w(input int unsigned width);
    return 2 * width;
  endfunction

  // SUM_W: width of a full-window sum; wide enough that N full-scale samples never wrap.
  function automatic int unsigned sum_w(input int unsigned width, input int unsigned log_n);
    return 2 * width + log_n;
  endfunction

endpackage

// File: rtl/sq_acc_out_reg.sv
// Valid/ready result register holding the window sum and, with SQ_ACC_PEAK_EN, the window peak.
module sq_acc_out_reg #(
  parameter int unsigned SUM_W = 20
`ifdef SQ_ACC_PEAK_EN
  , parameter int unsigned SQ_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SUM_W-1:0] load_sum,
`ifdef SQ_ACC_PEAK_EN
  input  logic [SQ_W-1:0]  load_peak,
  output logic [SQ_W-1:0]  out_peak,
`endif
  input  logic             out_ready,
  output logic             out_valid,
  output logic [SUM_W-1:0] out_sum
);

  // A new window wins over a same-cycle handshake so the stream continues without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
`ifdef SQ_ACC_PEAK_EN
      out_peak  <= '0;
`endif
    end else if (load) begin
      out_valid <= 1'b1;
      out_sum   <= load_sum;
`ifdef SQ_ACC_PEAK_EN
      out_peak  <= load_peak;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sq_window_acc.sv
// Windowed sum-of-squares accumulator: sums 2^LOG_N squared samples and presents sum and floor mean.
// Optional feature macro: SQ_ACC_PEAK_EN adds a per-window peak output (out_peak).
module sq_window_acc
  import sq_acc_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LOG_N = LOG_N_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*WIDTH-1:0]       in_sq,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH+LOG_N-1:0] out_sum,
`ifdef SQ_ACC_PEAK_EN
  output logic [2*WIDTH-1:0]       out_peak,
`endif
  output logic [2*WIDTH-1:0]       out_mean
);

  localparam int unsigned SAMPLE_W = sq_w(WIDTH);
  localparam int unsigned ACC_W    = sum_w(WIDTH, LOG_N);
  localparam logic [LOG_N-1:0] CNT_LAST = '1;

  acc_state_e        state;
  logic              run_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [LOG_N-1:0]  cnt;
  logic [LOG_N-1:0]  cnt_next;
  logic              accept;
  logic              last;
  logic              ov_next;
  logic              stall_next;

  // in_ready depends only on registered state plus the local clear, never on out_ready.
  assign in_ready = run_q & (state == ACC) & ~clear;
  assign accept   = in_valid & in_ready;
  assign last     = accept & (cnt == CNT_LAST);
  assign acc_sum  = acc + ACC_W'(in_sq);

  // Look ahead one edge so STALL is in force before an unconsumed result could be overwritten.
  assign cnt_next   = clear ? '0 : (accept ? cnt + LOG_N'(1) : cnt);
  assign ov_next    = last | (out_valid & ~out_ready);
  assign stall_next = (cnt_next == CNT_LAST) & ov_next;

`ifdef SQ_ACC_PEAK_EN
  logic [SAMPLE_W-1:0] peak;
  logic [SAMPLE_W-1:0] peak_max;

  assign peak_max = (in_sq > peak) ? in_sq : peak;

  always_ff @(posedge clk) begin
    if (rst) begin
      peak <= '0;
    end else if (clear) begin
      peak <= '0;
    end else if (accept) begin
      peak <= last ? '0 : peak_max;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      run_q <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= stall_next ? STALL : ACC;
      run_q <= 1'b1;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + LOG_N'(1);
        acc <= last ? '0 : acc_sum;
      end
    end
  end

  sq_acc_out_reg #(
    .SUM_W(ACC_W)
`ifdef SQ_ACC_PEAK_EN
    , .SQ_W(SAMPLE_W)
`endif
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (last),
    .load_sum  (acc_sum),
`ifdef SQ_ACC_PEAK_EN
    .load_peak (peak_max),
    .out_peak  (out_peak),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum)
  );

  assign out_mean = out_sum[ACC_W-1:LOG_N];

endmodule
